pipelined_control_unit: RTL
===========================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter OPW, default 4: opcode and function-code width.
REQ-002 Parameter RW, default 4: register-index width.
REQ-003 Parameter DRAIN_MAX, default 3: cycle bound for halt drain before forcing HALTED.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 opcode_id, funct_id  in  OPW  opcode and function code of the instruction in ID.
REQ-008 rs_id, rt_id, rd_id  in  RW  source and destination indices of the instruction in ID.
REQ-009 branch_taken  in  1  branch resolved taken in EX.
REQ-010 overflow  in  1  ALU overflow in EX.
REQ-011 stall  out  1  hold PC and IF/ID.
REQ-012 flush_id  out  1  discard the ID instruction.
REQ-013 branch, jump (1), offset_select, branch_select (2)  out  ID-stage controls.
REQ-014 alu_op (OPW), alu_src1 (2), alu_src2 (1)  out  EX-stage controls.
REQ-015 mem_read, mem_write, store_offset  out  1 each  MEM-stage controls.
REQ-016 reg_write, write_op2 (1), mem_to_reg (2)  out  WB-stage controls.
REQ-017 halted  out  1  pipeline drained and stopped.

Function
REQ-018 Opcodes: 0000 NOP, 0001 A-type, 1001 AND, 1010 OR, 0100 LBU, 0101 SB, 0110 LW, 0111 SW, 1100 BLT, 1101 BGT, 1110 BEQ, 0010 JMP, 0011 HALT; any other value decodes as NOP.
REQ-019 Internal EX, MEM and WB registers, each holding opcode, funct, rd, valid and a no_wb flag; they advance every cycle.
REQ-020 ID outputs are combinational from opcode_id:
  - AND/OR: offset_select=01.
  - BLT/BGT/BEQ: branch=1, offset_select=01, branch_select=00/01/10 respectively.
  - JMP: jump=1, offset_select=10.
  - All ID outputs are 0 while the FSM is not RUN or while flush_id=1.
REQ-021 EX outputs are decoded from the EX register:
  - alu_op = EX opcode for valid non-NOP instructions, otherwise 0.
  - alu_src1=01 for AND/OR; 10 for branches.
  - alu_src2=1 for LBU/SB/LW/SW.
REQ-022 MEM outputs: mem_read=1 for LBU/LW; mem_write=1 for SB/SW; store_offset=1 for SB.
REQ-023 WB outputs, all gated by valid and !no_wb:
  - reg_write=1 for A-type/AND/OR/LBU/LW.
  - mem_to_reg=00 for ALU instructions, 10 for LBU, 01 for LW.
  - write_op2=1 for A-type with funct=1111.
REQ-024 Latency: an instruction accepted in ID at edge N drives EX controls in cycle N+1, MEM controls in N+2 and WB controls in N+3.
REQ-025 Load-use: stall=1 in the same cycle when all of the following hold:
  - EX is a valid LBU/LW;
  - its rd equals rs_id or rt_id;
  - the ID opcode is not NOP/JMP/HALT.
REQ-026 While stalled, a bubble (valid=0) enters EX and the ID instruction is held; stall lasts exactly 1 cycle per hazard.
REQ-027 branch_taken is honoured only when EX holds a valid branch; then flush_id=1 and a bubble enters EX.
REQ-028 Flush has priority over stall and over HALT in ID.
REQ-029 overflow=1 with EX holding a valid A-type sets that instruction's no_wb flag; MEM behaviour is unaffected.
REQ-030 FSM states RUN, DRAIN, HALTED.
REQ-031 RUN -> DRAIN when HALT is in ID with no flush and no stall; a bubble enters EX.
REQ-032 In DRAIN, bubbles enter EX every cycle and stall=1.
REQ-033 DRAIN -> HALTED when EX, MEM and WB are all invalid, or after DRAIN_MAX cycles in DRAIN.
REQ-034 In HALTED: halted=1, stall=1, all stage controls 0; the FSM leaves HALTED only on rst.

Reset
REQ-035 rst=1 at a clock edge: FSM=RUN; all stage valid=0 and no_wb=0; all registered outputs 0 from the next cycle.
REQ-036 Reset mid-drain or mid-stall aborts the operation; the first instruction after reset release is accepted normally.

Verification
REQ-037 LW r3 then ADD reading r3 -> stall=1 for one cycle, EX bubble (alu_op=0), ADD reaches EX one cycle later; LW WB gives reg_write=1, mem_to_reg=01.
REQ-038 BEQ in EX with branch_taken=1 and HALT in ID -> flush_id=1, FSM stays RUN, halted=0.
REQ-039 A-type funct=1111 with overflow=1 in EX -> 2 cycles later reg_write=0 and write_op2=0; the same instruction without overflow gives reg_write=1 and write_op2=1.
REQ-040 SB followed by HALT -> mem_write=1 and store_offset=1 in MEM; halted=1 exactly 3 cycles after HALT is accepted, with all controls 0.
REQ-041 rst asserted during DRAIN -> next cycle halted=0 and stall=0; a following AND in ID produces offset_select=01.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Control unit for a 4-stage-control pipeline: combinational ID decode, EX/MEM/WB control
// registers, load-use stall, branch flush, overflow write-back suppression and a halt drain FSM.
module pipelined_control_unit #(
  parameter int unsigned OPW       = 4,
  parameter int unsigned RW        = 4,
  parameter int unsigned DRAIN_MAX = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode_id,
  input  logic [OPW-1:0] funct_id,
  input  logic [RW-1:0]  rs_id,
  input  logic [RW-1:0]  rt_id,
  input  logic [RW-1:0]  rd_id,
  input  logic           branch_taken,
  input  logic           overflow,
  output logic           stall,
  output logic           flush_id,
  output logic           branch,
  output logic           jump,
  output logic [1:0]     offset_select,
  output logic [1:0]     branch_select,
  output logic [OPW-1:0] alu_op,
  output logic [1:0]     alu_src1,
  output logic           alu_src2,
  output logic           mem_read,
  output logic           mem_write,
  output logic           store_offset,
  output logic           reg_write,
  output logic           write_op2,
  output logic [1:0]     mem_to_reg,
  output logic           halted
);

  localparam logic [OPW-1:0] OpNop   = OPW'(4'b0000);
  localparam logic [OPW-1:0] OpAtype = OPW'(4'b0001);
  localparam logic [OPW-1:0] OpJmp   = OPW'(4'b0010);
  localparam logic [OPW-1:0] OpHalt  = OPW'(4'b0011);
  localparam logic [OPW-1:0] OpLbu   = OPW'(4'b0100);
  localparam logic [OPW-1:0] OpSb    = OPW'(4'b0101);
  localparam logic [OPW-1:0] OpLw    = OPW'(4'b0110);
  localparam logic [OPW-1:0] OpSw    = OPW'(4'b0111);
  localparam logic [OPW-1:0] OpAnd   = OPW'(4'b1001);
  localparam logic [OPW-1:0] OpOr    = OPW'(4'b1010);
  localparam logic [OPW-1:0] OpBlt   = OPW'(4'b1100);
  localparam logic [OPW-1:0] OpBgt   = OPW'(4'b1101);
  localparam logic [OPW-1:0] OpBeq   = OPW'(4'b1110);
  localparam logic [OPW-1:0] FunctOp2 = OPW'(4'b1111);

  localparam int unsigned CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX + 1) : 1;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [OPW-1:0] funct;
    logic [RW-1:0]  rd;
    logic           valid;
    logic           no_wb;
  } stage_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_t;

  // Unknown opcodes are folded to NOP on entry so every later decode sees legal values only.
  function automatic logic [OPW-1:0] norm_op(input logic [OPW-1:0] op);
    case (op)
      OpNop, OpAtype, OpJmp, OpHalt, OpLbu, OpSb, OpLw, OpSw,
      OpAnd, OpOr, OpBlt, OpBgt, OpBeq: norm_op = op;
      default:                          norm_op = OpNop;
    endcase
  endfunction

  state_t          state_q;
  logic [CW-1:0]   drain_cnt_q;
  stage_t          ex_q, mem_q, wb_q;
  stage_t          ex_d, mem_d;
  logic [OPW-1:0]  id_op;
  logic            run, active;
  logic            ex_is_load, ex_is_branch;
  logic            id_uses_regs, load_use;
  logic            accept, halt_go, stages_empty;
  logic            unused_wb_rd;

  assign id_op        = norm_op(opcode_id);
  assign run          = (state_q == StRun);
  assign active       = (state_q != StHalted);
  assign ex_is_load   = ex_q.valid && (ex_q.op == OpLbu || ex_q.op == OpLw);
  assign ex_is_branch = ex_q.valid && (ex_q.op == OpBlt || ex_q.op == OpBgt || ex_q.op == OpBeq);
  assign id_uses_regs = !(id_op == OpNop || id_op == OpJmp || id_op == OpHalt);
  assign load_use     = ex_is_load && id_uses_regs && (ex_q.rd == rs_id || ex_q.rd == rt_id);

  assign flush_id     = run && ex_is_branch && branch_taken;
  assign accept       = run && !flush_id && !load_use && (id_op != OpHalt);
  assign halt_go      = run && !flush_id && !load_use && (id_op == OpHalt);
  assign stall        = !run || (!flush_id && load_use);
  assign stages_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid;
  assign unused_wb_rd = ^wb_q.rd;

  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.op    = id_op;
      ex_d.funct = funct_id;
      ex_d.rd    = rd_id;
      ex_d.valid = 1'b1;
    end
    mem_d = ex_q;
    // Overflow only suppresses write-back; the instruction still travels through MEM.
    mem_d.no_wb = ex_q.no_wb | (ex_q.valid && ex_q.op == OpAtype && overflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      halted      <= 1'b0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
      case (state_q)
        StRun: begin
          if (halt_go) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (stages_empty || drain_cnt_q == CW'(DRAIN_MAX - 1)) begin
            state_q <= StHalted;
            halted  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    branch        = 1'b0;
    jump          = 1'b0;
    offset_select = 2'b00;
    branch_select = 2'b00;
    alu_op        = '0;
    alu_src1      = 2'b00;
    alu_src2      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    store_offset  = 1'b0;
    reg_write     = 1'b0;
    write_op2     = 1'b0;
    mem_to_reg    = 2'b00;

    if (run && !flush_id) begin
      case (id_op)
        OpAnd, OpOr: offset_select = 2'b01;
        OpBlt: begin branch = 1'b1; offset_select = 2'b01; branch_select = 2'b00; end
        OpBgt: begin branch = 1'b1; offset_select = 2'b01; branch_select = 2'b01; end
        OpBeq: begin branch = 1'b1; offset_select = 2'b01; branch_select = 2'b10; end
        OpJmp: begin jump = 1'b1; offset_select = 2'b10; end
        default: ;
      endcase
    end

    if (active && ex_q.valid) begin
      alu_op = ex_q.op;
      case (ex_q.op)
        OpAnd, OpOr:         alu_src1 = 2'b01;
        OpBlt, OpBgt, OpBeq: alu_src1 = 2'b10;
        default: ;
      endcase
      alu_src2 = (ex_q.op == OpLbu || ex_q.op == OpSb || ex_q.op == OpLw || ex_q.op == OpSw);
    end

    if (active && mem_q.valid) begin
      mem_read     = (mem_q.op == OpLbu || mem_q.op == OpLw);
      mem_write    = (mem_q.op == OpSb || mem_q.op == OpSw);
      store_offset = (mem_q.op == OpSb);
    end

    if (active && wb_q.valid && !wb_q.no_wb) begin
      case (wb_q.op)
        OpAtype: begin reg_write = 1'b1; write_op2 = (wb_q.funct == FunctOp2); end
        OpAnd, OpOr: reg_write = 1'b1;
        OpLbu: begin reg_write = 1'b1; mem_to_reg = 2'b10; end
        OpLw:  begin reg_write = 1'b1; mem_to_reg = 2'b01; end
        default: ;
      endcase
    end
  end

endmodule
